// File: rtl/jtaguart_pkg.sv
// Shared types and constants for the JTAG UART transmit path.
package jtaguart_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned JTAGUART_TX_DEPTH_LOG2_DEFAULT = 4;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/jtaguart_fifo_ram.sv
// Byte storage for the tx FIFO: one synchronous write port, one asynchronous read port.
module jtaguart_fifo_ram
    import jtaguart_pkg::*;
#(
    parameter int unsigned ADDR_W = JTAGUART_TX_DEPTH_LOG2_DEFAULT
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  byte_t             wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output byte_t             rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    byte_t r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/jtaguart_tx_fifo.sv
// Byte FIFO between a producer and the JTAG UART tx port, with ready/valid on both sides.
// Optional counters (tx_bytes, stall_cycles) appear when JTAGUART_TX_STATS_EN is defined.
module jtaguart_tx_fifo
    import jtaguart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = JTAGUART_TX_DEPTH_LOG2_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  byte_t               in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output byte_t               out_data,
    output logic [DEPTH_LOG2:0] level
`ifdef JTAGUART_TX_STATS_EN
    ,
    output logic [31:0]         tx_bytes,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
    localparam int unsigned LEVEL_W = DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W   = DEPTH_LOG2;

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    // Handshake flags come only from registered state (plus reset gating on in_ready).
    assign w_full    = (r_level == LEVEL_W'(DEPTH));
    assign w_empty   = (r_level == LEVEL_W'(0));
    assign in_ready  = !reset && !w_full;
    assign out_valid = !w_empty;
    assign level     = r_level;

    // A flush discards any same-cycle push, so storage is not written then.
    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LEVEL_W'(1);
            2'b01:   w_level_nxt = r_level - LEVEL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_nxt;
        end
    end

    jtaguart_fifo_ram #(
        .ADDR_W (PTR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (in_data),
        .rd_addr (r_rd_ptr),
        .rd_data (out_data)
    );

`ifdef JTAGUART_TX_STATS_EN
    logic [31:0] r_tx_bytes;
    logic [31:0] r_stall_cycles;

    // tx_bytes wraps; stall_cycles saturates. Neither is cleared by flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_bytes     <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_pop) begin
                r_tx_bytes <= r_tx_bytes + 32'd1;
            end
            if (out_valid && !out_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign tx_bytes     = r_tx_bytes;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_jtaguart_tx_fifo.sv
// Self-checking bench for jtaguart_tx_fifo against a queue-based reference model.
// Define JTAGUART_TX_STATS_EN to also exercise the statistics counters.
module tb_jtaguart_tx_fifo;
    import jtaguart_pkg::*;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 2 ** DL2;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    byte_t       in_data;
    logic        out_valid;
    logic        out_ready;
    byte_t       out_data;
    logic [DL2:0] level;
`ifdef JTAGUART_TX_STATS_EN
    logic [31:0] tx_bytes;
    logic [31:0] stall_cycles;
    logic [31:0] m_tx;
    logic [31:0] m_stall;
`endif

    jtaguart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level)
`ifdef JTAGUART_TX_STATS_EN
        ,
        .tx_bytes     (tx_bytes),
        .stall_cycles (stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int    n_tests;
    int    n_fail;
    byte_t q[$];

    logic        obs_in_ready, obs_out_valid;
    byte_t       obs_out_data;
    logic [DL2:0] obs_level;
    logic        exp_in_ready, exp_out_valid;
    byte_t       exp_out_data;
    logic [DL2:0] exp_level;

    // Drive one cycle, sample outputs before the edge, advance the model, then step past the edge.
    task automatic do_cycle(input logic iv, input byte_t id, input logic ordy,
                            input logic fl, input logic rst);
        logic push;
        logic pop;
        reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        obs_out_data  = out_data;
        obs_level     = level;
        exp_in_ready  = !rst && (q.size() < int'(DEPTH));
        exp_out_valid = (q.size() != 0);
        exp_out_data  = exp_out_valid ? q[0] : 8'h00;
        exp_level     = (DL2+1)'(q.size());
        if (rst) begin
            q.delete();
`ifdef JTAGUART_TX_STATS_EN
            m_tx = 0; m_stall = 0;
`endif
        end else begin
            pop  = exp_out_valid && ordy;
            push = iv && exp_in_ready && !fl;
`ifdef JTAGUART_TX_STATS_EN
            if (pop) m_tx = m_tx + 1;
            if (exp_out_valid && !ordy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
            if (fl) q.delete();
            else begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(id);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        do_cycle(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        do_cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_tests++;
        if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
`ifdef JTAGUART_TX_STATS_EN
        n_tests++;
        if (tx_bytes !== 32'd0 || stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_stats got %0d/%0d exp 0/0", tx_bytes, stall_cycles);
        end
`endif
        reset = 1'b0; in_valid = 1'b0; #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single_stall();
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h41 || level !== 5'd1) begin
            n_fail++; $display("FAIL latency got v=%b d=%h l=%0d exp v=1 d=41 l=1", out_valid, out_data, level);
        end
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (out_data !== 8'h41 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold cyc %0d got v=%b d=%h exp v=1 d=41", i, out_valid, out_data);
            end
        end
`ifdef JTAGUART_TX_STATS_EN
        n_tests++;
        if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL stall_count got %0d exp 5", stall_cycles); end
`endif
    endtask

    task automatic test_fill_drain();
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs_in_ready !== (i < 16)) begin
                n_fail++; $display("FAIL fill_in_ready cyc %0d got %b exp %b", i, obs_in_ready, (i < 16));
            end
        end
        n_tests++;
        if (level !== 5'd16) begin n_fail++; $display("FAIL fill_level got %0d exp 16", level); end
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs_out_valid !== 1'b1 || obs_out_data !== 8'(8'h20 + i)) begin
                n_fail++; $display("FAIL drain_data idx %0d got %h exp %h", i, obs_out_data, 8'(8'h20 + i));
            end
        end
        n_tests++;
        if (out_valid !== 1'b0 || level !== '0) begin
            n_fail++; $display("FAIL drain_empty got v=%b l=%0d exp v=0 l=0", out_valid, level);
        end
    endtask

    task automatic test_full_push_pop();
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_in_ready !== 1'b0 || level !== 5'd15) begin
            n_fail++; $display("FAIL full_pop_only got rdy=%b l=%0d exp rdy=0 l=15", obs_in_ready, level);
        end
        do_cycle(1'b1, 8'hC4, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_in_ready !== 1'b1 || level !== 5'd15) begin
            n_fail++; $display("FAIL push_pop_level got rdy=%b l=%0d exp rdy=1 l=15", obs_in_ready, level);
        end
        while (q.size() != 0) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs_out_data !== exp_out_data) begin
                n_fail++; $display("FAIL full_drain got %h exp %h", obs_out_data, exp_out_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rx;
        rx = 0;
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 1001; k++) begin
            do_cycle(k < 1000, 8'(32 + (k % 96)), 1'b1, 1'b0, 1'b0);
            if (k < 1000) begin
                n_tests++;
                if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready k %0d got %b exp 1", k, obs_in_ready); end
            end
            if (obs_out_valid === 1'b1) begin
                n_tests++;
                if (obs_out_data !== 8'(32 + (rx % 96))) begin
                    n_fail++; $display("FAIL stream_data idx %0d got %h exp %h", rx, obs_out_data, 8'(32 + (rx % 96)));
                end
                rx++;
            end
        end
        n_tests++;
        if (rx != 1000) begin n_fail++; $display("FAIL stream_count got %0d exp 1000", rx); end
`ifdef JTAGUART_TX_STATS_EN
        n_tests++;
        if (tx_bytes !== 32'd1000) begin n_fail++; $display("FAIL stream_tx_bytes got %0d exp 1000", tx_bytes); end
`endif
    endtask

    task automatic test_flush();
`ifdef JTAGUART_TX_STATS_EN
        logic [31:0] tx_before;
`endif
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) do_cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (level !== 5'd7) begin n_fail++; $display("FAIL flush_pre_level got %0d exp 7", level); end
`ifdef JTAGUART_TX_STATS_EN
        tx_before = tx_bytes;
`endif
        do_cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (level !== '0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear got l=%0d v=%b exp l=0 v=0", level, out_valid);
        end
`ifdef JTAGUART_TX_STATS_EN
        n_tests++;
        if (tx_bytes !== tx_before || tx_bytes !== 32'd1) begin
            n_fail++; $display("FAIL flush_tx_bytes got %0d exp 1", tx_bytes);
        end
`endif
        do_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (out_data !== 8'h55 || level !== 5'd1) begin
            n_fail++; $display("FAIL flush_next_byte got d=%h l=%0d exp d=55 l=1", out_data, level);
        end
    endtask

    task automatic test_reset_mid();
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_in_ready got %b exp 0", obs_in_ready); end
        n_tests++;
        if (level !== '0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_clear got l=%0d v=%b exp l=0 v=0", level, out_valid);
        end
`ifdef JTAGUART_TX_STATS_EN
        n_tests++;
        if (tx_bytes !== 32'd0 || stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset_stats got %0d/%0d exp 0/0", tx_bytes, stall_cycles);
        end
`endif
        do_cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (out_data !== 8'h77 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_first got v=%b d=%h exp v=1 d=77", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        logic rst;
        logic fl;
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(99) == 0);
            fl  = ($urandom_range(31) == 0);
            do_cycle(1'($urandom), 8'($urandom), ($urandom_range(3) != 0) ^ (c >= 300),
                     fl, rst);
            n_tests++;
            if ({obs_in_ready, obs_out_valid, obs_level} !== {exp_in_ready, exp_out_valid, exp_level}) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d got rdy=%b v=%b l=%0d exp rdy=%b v=%b l=%0d", c,
                         obs_in_ready, obs_out_valid, obs_level, exp_in_ready, exp_out_valid, exp_level);
            end
            if (exp_out_valid) begin
                n_tests++;
                if (obs_out_data !== exp_out_data) begin
                    n_fail++; $display("FAIL rand_data cyc %0d got %h exp %h", c, obs_out_data, exp_out_data);
                end
            end
        end
`ifdef JTAGUART_TX_STATS_EN
        n_tests++;
        if (tx_bytes !== m_tx || stall_cycles !== m_stall) begin
            n_fail++; $display("FAIL rand_stats got %0d/%0d exp %0d/%0d", tx_bytes, stall_cycles, m_tx, m_stall);
        end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
`ifdef JTAGUART_TX_STATS_EN
        m_tx = 0; m_stall = 0;
`endif
        test_reset();
        test_single_stall();
        test_fill_drain();
        test_full_push_pop();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtaguart_tx_fifo.md
JTAGUART_TX_FIFO -- requirements
Module: jtaguart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of storage depth (DEPTH = 2**DEPTH_LOG2, legal 1..10).
REQ-002 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous discard of all stored bytes.
REQ-005 SHALL have port in_valid  input  1  producer offers in_data.
REQ-006 SHALL have port in_ready  output  1  FIFO accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  8  byte from producer.
REQ-008 SHALL have port out_valid  output  1  byte available to the JTAG UART tx port.
REQ-009 SHALL have port out_ready  input  1  JTAG UART tx port accepts out_data.
REQ-010 SHALL have port out_data  output  8  head-of-FIFO byte.
REQ-011 SHALL have port level  output  DEPTH_LOG2+1  number of stored bytes.

Function
REQ-012 SHALL accept a byte on cycles where in_valid && in_ready, and SHALL deliver one on cycles where out_valid && out_ready.
REQ-013 SHALL deliver bytes in acceptance order, without loss or duplication.
REQ-014 SHALL drive in_ready = !reset && (level != DEPTH), from registered state only; in_ready SHALL NOT depend on out_ready.
REQ-015 SHALL drive out_valid = (level != 0) and out_data = entry at read pointer; both registered-state-derived, no combinational path from in_*.
REQ-016 SHALL give latency of exactly 1 cycle: a byte accepted at edge N into an empty FIFO appears with out_valid=1 after edge N.
REQ-017 SHALL hold out_data stable while out_valid && !out_ready.
REQ-018 SHALL, on simultaneous push and pop, leave level unchanged and advance both pointers.
REQ-019 SHALL wrap read and write pointers modulo DEPTH.
REQ-020 SHALL, when full (level = DEPTH) with out_ready=1, pop only; the push is refused that cycle because in_ready=0.
REQ-021 SHALL, when empty, ignore out_ready; level SHALL never underflow or exceed DEPTH.
REQ-022 SHALL, on flush=1, set level and both pointers to 0 at the next edge, discarding any same-cycle push; flush SHALL NOT reset stats counters.

Reset
REQ-023 SHALL, on reset=1 at an edge, set level=0, pointers=0, and therefore out_valid=0; storage contents need not be cleared.
REQ-024 SHALL force in_ready=0 throughout reset and SHALL ignore in_valid, out_ready and flush while reset=1.
REQ-025 SHALL, on reset mid-operation, discard stored bytes; the first byte accepted after reset deassertion is the first byte delivered.

Configuration
REQ-026 SHALL, with macro JTAGUART_TX_STATS_EN defined, add output tx_bytes[31:0]: count of out handshakes, wrapping modulo 2**32, reset to 0.
REQ-027 SHALL, with JTAGUART_TX_STATS_EN defined, add output stall_cycles[31:0]: count of cycles with out_valid && !out_ready, saturating at 32'hFFFFFFFF, reset to 0.
REQ-028 SHALL, without JTAGUART_TX_STATS_EN, omit both ports and counters; FIFO behaviour SHALL be identical either way.

Structure
REQ-029 SHALL take byte_t (8-bit) typedef and JTAGUART_TX_DEPTH_LOG2_DEFAULT constant from shared package jtaguart_pkg.
REQ-030 SHALL implement storage in one sub-module, jtaguart_fifo_ram: one write port, one asynchronous read port, DEPTH x 8.
REQ-031 SHALL keep pointers, level, handshake and stats logic in jtaguart_tx_fifo.

Verification
REQ-032 Reset then push 8'h41 with out_ready=0 -> after one edge out_valid=1, out_data=8'h41, level=1; data held for 5 stalled cycles, stall_cycles=5 (stats build).
REQ-033 DEPTH_LOG2=4, out_ready=0, in_valid=1 for 20 cycles of bytes 8'h20..8'h33 -> in_ready drops after 16 accepts, level=16; drain yields 8'h20..8'h2F in order.
REQ-034 Full FIFO, in_valid=1 and out_ready=1 together -> one pop, no push, level=15; next cycle push and pop both occur, level stays 15.
REQ-035 Continuous in_valid/out_ready=1 for 1000 bytes cycling 8'd32..8'd127 -> output sequence matches input, pointers wrap, tx_bytes=1000.
REQ-036 level=7, assert flush with in_valid=1 -> next cycle level=0, out_valid=0, pushed byte never appears; tx_bytes unchanged.
REQ-037 level=5, assert reset for 1 cycle with in_valid=1 -> in_ready=0 during reset, after it level=0, out_valid=0, tx_bytes=0, stall_cycles=0.
